// File: rtl/encoder4to2_pending_pkg.sv
// -----------------------------------------------------------------------------
// encoder4to2_pending_pkg
// Shared constants and types for the pending-request priority encoder.
//   REQ_W   : number of request lines
//   ENC_W   : width of the encoded index
//   state_e : handshake state (ST_IDLE = nothing presented, ST_HOLD = o valid)
// -----------------------------------------------------------------------------
`ifndef ENCODER4TO2_PENDING_PKG_SV
`define ENCODER4TO2_PENDING_PKG_SV

package encoder4to2_pending_pkg;

  localparam int REQ_W = 4;
  localparam int ENC_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

`endif

// File: rtl/encoder4to2_pending_pri_enc.sv
// -----------------------------------------------------------------------------
// pri_enc4to2
// Combinational 4-to-2 priority encoder.
//   req[3:0] : request vector
//   idx[1:0] : index of the highest-priority set bit (00 when none set)
//   any      : at least one request bit is set
// LOW_FIRST = 0 gives bit 3 the highest priority; LOW_FIRST = 1 gives bit 0.
// -----------------------------------------------------------------------------
module pri_enc4to2
  import encoder4to2_pending_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b0
) (
  input  logic [REQ_W-1:0] req,
  output logic [ENC_W-1:0] idx,
  output logic             any
);

  // NOTE: idx gets a default before the case so no path leaves it unassigned;
  // otherwise synthesis would infer a latch to hold its old value.
  always_comb begin
    idx = '0;
    any = |req;
    if (LOW_FIRST) begin
      casez (req)
        4'b???1: idx = 2'd0;
        4'b??10: idx = 2'd1;
        4'b?100: idx = 2'd2;
        4'b1000: idx = 2'd3;
        default: idx = 2'd0;
      endcase
    end else begin
      casez (req)
        4'b1???: idx = 2'd3;
        4'b01??: idx = 2'd2;
        4'b001?: idx = 2'd1;
        default: idx = 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/encoder4to2_pending.sv
// -----------------------------------------------------------------------------
// encoder4to2_pending
// Registered 4-to-2 priority encoder with sticky pending requests and a
// valid/ack handshake. Requests on i (gated by En) accumulate in a pending
// register; the highest-priority one is presented on o with valid=1 and held
// stable until ack, at which point that bit is cleared and the next one is
// loaded without a bubble.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   i     : request lines, level-sampled each clock
//   En    : capture enable for i
//   o     : index of the presented request (00 after reset, held while idle)
//   valid : o holds a pending request
//   ack   : consumer accepts o (ignored while valid=0)
//   busy  : OR of the pending register
// -----------------------------------------------------------------------------
module encoder4to2_pending
  import encoder4to2_pending_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_W-1:0] i,
  input  logic             En,
  output logic [ENC_W-1:0] o,
  output logic             valid,
  input  logic             ack,
  output logic             busy
);

  state_e            state_q, state_d;
  logic [REQ_W-1:0]  pend_q,  pend_d;
  logic [ENC_W-1:0]  o_q,     o_d;
  logic [REQ_W-1:0]  clr;
  logic [ENC_W-1:0]  sel;
  logic              sel_any;
  logic              take;

  // The presented bit is cleared only when the consumer actually accepts it.
  assign take = (state_q == ST_HOLD) && ack;
  assign clr  = take ? (REQ_W'(1) << o_q) : '0;

  // New requests are OR-ed in after the clear, so a re-request of the bit
  // being acknowledged survives and is served again later.
  assign pend_d = (pend_q & ~clr) | (i & {REQ_W{En}});

  pri_enc4to2 #(
    .LOW_FIRST (LOW_FIRST)
  ) u_pri_enc (
    .req (pend_d),
    .idx (sel),
    .any (sel_any)
  );

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          o_d     = sel;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // o is frozen until ack, even if a higher-priority request arrives.
        if (ack) begin
          if (sel_any) begin
            o_d = sel;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      o_q     <= o_d;
    end
  end

  assign o     = o_q;
  assign valid = (state_q == ST_HOLD);
  assign busy  = |pend_q;

endmodule

// File: tb/tb_encoder4to2_pending.sv
// -----------------------------------------------------------------------------
// tb_encoder4to2_pending
// Directed bench for encoder4to2_pending: one instance with LOW_FIRST=0 and
// one with LOW_FIRST=1, each with its own request/enable/ack inputs.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_encoder4to2_pending;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i0, i1;
  logic       en0, en1;
  logic       ack0, ack1;
  logic [1:0] o0, o1;
  logic       valid0, valid1;
  logic       busy0, busy1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  encoder4to2_pending #(.LOW_FIRST(1'b0)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .i     (i0),
    .En    (en0),
    .o     (o0),
    .valid (valid0),
    .ack   (ack0),
    .busy  (busy0)
  );

  encoder4to2_pending #(.LOW_FIRST(1'b1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .i     (i1),
    .En    (en1),
    .o     (o1),
    .valid (valid1),
    .ack   (ack1),
    .busy  (busy1)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check all three outputs of the LOW_FIRST=0 instance.
  task automatic exp0(input string tag, input logic [1:0] o_e, input logic v_e, input logic b_e);
    check({tag, ".o"},     {2'b00, o0},     {2'b00, o_e});
    check({tag, ".valid"}, {3'b000, valid0}, {3'b000, v_e});
    check({tag, ".busy"},  {3'b000, busy0},  {3'b000, b_e});
  endtask

  task automatic exp1(input string tag, input logic [1:0] o_e, input logic v_e, input logic b_e);
    check({tag, ".o"},     {2'b00, o1},     {2'b00, o_e});
    check({tag, ".valid"}, {3'b000, valid1}, {3'b000, v_e});
    check({tag, ".busy"},  {3'b000, busy1},  {3'b000, b_e});
  endtask

  initial begin
    rst = 1'b1; i0 = 4'b1111; en0 = 1'b1; ack0 = 1'b0;
    i1 = 4'b0000; en1 = 1'b1; ack1 = 1'b0;

    // 1. Reset sanity: requests during reset are ignored.
    tick(); exp0("rst_c1", 2'b00, 1'b0, 1'b0);
    tick(); exp0("rst_c2", 2'b00, 1'b0, 1'b0);
    rst = 1'b0; i0 = 4'b0000;
    tick(); exp0("rst_rel", 2'b00, 1'b0, 1'b0);

    // ack while idle is ignored.
    ack0 = 1'b1;
    tick(); exp0("ack_idle", 2'b00, 1'b0, 1'b0);
    ack0 = 1'b0;

    // 2. Priority and back-to-back service order.
    i0 = 4'b1010;
    tick(); exp0("prio_first", 2'b11, 1'b1, 1'b1);
    i0 = 4'b0000; ack0 = 1'b1;
    tick(); exp0("prio_second", 2'b01, 1'b1, 1'b1);
    tick(); exp0("prio_done", 2'b01, 1'b0, 1'b0);
    ack0 = 1'b0;

    // 3. Hold stability: a higher-priority arrival does not disturb o.
    i0 = 4'b0001;
    tick(); exp0("hold_load", 2'b00, 1'b1, 1'b1);
    i0 = 4'b0000;
    tick(); tick();
    i0 = 4'b1000;
    tick(); exp0("hold_hi_arr", 2'b00, 1'b1, 1'b1);
    i0 = 4'b0000;
    tick(); exp0("hold_still", 2'b00, 1'b1, 1'b1);
    ack0 = 1'b1;
    tick(); exp0("hold_acked", 2'b11, 1'b1, 1'b1);
    tick(); exp0("hold_done", 2'b11, 1'b0, 1'b0);
    ack0 = 1'b0;

    // 4. Ack and re-request of the same bit in one cycle: set wins.
    i0 = 4'b0100;
    tick(); exp0("rereq_load", 2'b10, 1'b1, 1'b1);
    ack0 = 1'b1;
    tick(); exp0("rereq_again", 2'b10, 1'b1, 1'b1);
    i0 = 4'b0000;
    tick(); exp0("rereq_done", 2'b10, 1'b0, 1'b0);
    ack0 = 1'b0;

    // 5a. En=0 blocks capture.
    en0 = 1'b0; i0 = 4'b1111;
    tick(); exp0("en_off_1", 2'b10, 1'b0, 1'b0);
    tick(); exp0("en_off_2", 2'b10, 1'b0, 1'b0);

    // 5b. En=0 still lets pending requests drain.
    en0 = 1'b1; i0 = 4'b1100;
    tick(); exp0("drain_load", 2'b11, 1'b1, 1'b1);
    en0 = 1'b0; i0 = 4'b0011; ack0 = 1'b1;
    tick(); exp0("drain_next", 2'b10, 1'b1, 1'b1);
    tick(); exp0("drain_done", 2'b10, 1'b0, 1'b0);
    ack0 = 1'b0; i0 = 4'b0000;

    // 5c. Reset mid-handshake drops pending requests.
    en0 = 1'b1; i0 = 4'b0110;
    tick(); exp0("mrst_load", 2'b10, 1'b1, 1'b1);
    i0 = 4'b0000; rst = 1'b1;
    tick(); exp0("mrst_rst", 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); exp0("mrst_lost", 2'b00, 1'b0, 1'b0);
    tick(); exp0("mrst_lost2", 2'b00, 1'b0, 1'b0);

    // 6. LOW_FIRST=1 instance serves bit 1 before bit 3.
    exp1("lf_idle", 2'b00, 1'b0, 1'b0);
    i1 = 4'b1010;
    tick(); exp1("lf_first", 2'b01, 1'b1, 1'b1);
    i1 = 4'b0000; ack1 = 1'b1;
    tick(); exp1("lf_second", 2'b11, 1'b1, 1'b1);
    tick(); exp1("lf_done", 2'b11, 1'b0, 1'b0);
    ack1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
